// File: rtl/valu_issue_queue.sv
// Issue queue feeding the VALU over the shared FLU port, with writeback ID checking.
// Optional saturating dispatch/stall counters when VALU_ISSUE_STATS_EN is defined.
`timescale 1ns/1ps

module valu_issue_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_operand_a_i,
    input  logic [DATA_W-1:0]          in_operand_b_i,
    input  logic [TRANS_ID_BITS-1:0]   in_trans_id_i,
    input  logic                       flu_busy_i,
    input  logic                       valu_ready_i,
    output logic                       valu_valid_o,
    output logic [DATA_W-1:0]          operand_a_o,
    output logic [DATA_W-1:0]          operand_b_o,
    output logic [TRANS_ID_BITS-1:0]   trans_id_o,
    input  logic                       flu_valid_i,
    input  logic [TRANS_ID_BITS-1:0]   flu_trans_id_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       wb_mismatch_o
`ifdef VALU_ISSUE_STATS_EN
    ,
    output logic [31:0]                dispatch_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_WAIT_WB = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0]        a;
        logic [DATA_W-1:0]        b;
        logic [TRANS_ID_BITS-1:0] id;
    } entry_t;

    entry_t                   mem_q [DEPTH];
    entry_t                   head;
    entry_t                   in_entry;

    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [1:0]               state_q, state_d;
    logic [TRANS_ID_BITS-1:0] exp_id_q, exp_id_d;
    logic                     wait_q, wait_d;
    logic                     mismatch_q, mismatch_d;
    logic                     full, empty, enq, deq, grant, nonempty_d;

    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign enq   = in_valid_i && !full && !flush_i;
    assign grant = valu_ready_i && !flu_busy_i;
    assign deq   = (state_q == ST_ARMED) && grant && !empty && !flush_i;
    assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

    assign in_entry = '{a: in_operand_a_i, b: in_operand_b_i, id: in_trans_id_i};

    assign in_ready_o    = !full;
    assign count_o       = wr_ptr_q - rd_ptr_q;
    assign wb_mismatch_o = mismatch_q;
    assign valu_valid_o  = deq;
    assign operand_a_o   = deq ? head.a  : '0;
    assign operand_b_o   = deq ? head.b  : '0;
    assign trans_id_o    = deq ? head.id : '0;

    // Next-state: pointers first so the FSM can look at next-cycle occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d   = rd_ptr_q + PTR_W'(deq);
        state_d    = state_q;
        exp_id_d   = exp_id_q;
        wait_d     = wait_q;
        mismatch_d = mismatch_q;
        nonempty_d = (wr_ptr_d != rd_ptr_d);

        case (state_q)
            ST_IDLE: begin
                if (nonempty_d) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (deq) begin
                    exp_id_d = head.id;
                    // Single-cycle VALU: a same-cycle writeback retires the op immediately.
                    if (flu_valid_i && (flu_trans_id_i == head.id)) begin
                        state_d = nonempty_d ? ST_ARMED : ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_WB;
                        wait_d  = 1'b0;
                    end
                end
            end
            ST_WAIT_WB: begin
                if (flu_valid_i && (flu_trans_id_i == exp_id_q)) begin
                    state_d = nonempty_d ? ST_ARMED : ST_IDLE;
                end else if (wait_q) begin
                    mismatch_d = 1'b1;
                    state_d    = nonempty_d ? ST_ARMED : ST_IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            state_d    = ST_IDLE;
            exp_id_d   = '0;
            wait_d     = 1'b0;
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            exp_id_q   <= '0;
            wait_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            exp_id_q   <= exp_id_d;
            wait_q     <= wait_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q[IDX_W-1:0]] <= in_entry;
    end

`ifdef VALU_ISSUE_STATS_EN
    logic [31:0] dispatch_cnt_q, stall_cnt_q;

    // Saturating counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dispatch_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (deq && (dispatch_cnt_q != '1)) dispatch_cnt_q <= dispatch_cnt_q + 32'd1;
            if ((state_q == ST_ARMED) && !grant && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign dispatch_cnt_o = dispatch_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_valu_issue_queue.sv
// Directed self-checking bench for valu_issue_queue.
`timescale 1ns/1ps

module tb_valu_issue_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TID_W  = 3;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_operand_a_i;
    logic [DATA_W-1:0] in_operand_b_i;
    logic [TID_W-1:0]  in_trans_id_i;
    logic              flu_busy_i;
    logic              valu_ready_i;
    logic              valu_valid_o;
    logic [DATA_W-1:0] operand_a_o;
    logic [DATA_W-1:0] operand_b_o;
    logic [TID_W-1:0]  trans_id_o;
    logic              flu_valid_i;
    logic [TID_W-1:0]  flu_trans_id_i;
    logic [CNT_W-1:0]  count_o;
    logic              wb_mismatch_o;
`ifdef VALU_ISSUE_STATS_EN
    logic [31:0]       dispatch_cnt_o;
    logic [31:0]       stall_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    valu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TRANS_ID_BITS(TID_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_operand_a_i (in_operand_a_i),
        .in_operand_b_i (in_operand_b_i),
        .in_trans_id_i  (in_trans_id_i),
        .flu_busy_i     (flu_busy_i),
        .valu_ready_i   (valu_ready_i),
        .valu_valid_o   (valu_valid_o),
        .operand_a_o    (operand_a_o),
        .operand_b_o    (operand_b_o),
        .trans_id_o     (trans_id_o),
        .flu_valid_i    (flu_valid_i),
        .flu_trans_id_i (flu_trans_id_i),
        .count_o        (count_o),
        .wb_mismatch_o  (wb_mismatch_o)
`ifdef VALU_ISSUE_STATS_EN
        ,
        .dispatch_cnt_o (dispatch_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic drive_enq(input logic [TID_W-1:0] id, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        in_valid_i     = 1'b1;
        in_trans_id_i  = id;
        in_operand_a_i = a;
        in_operand_b_i = b;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        in_operand_a_i = '0; in_operand_b_i = '0; in_trans_id_i = '0;
        flu_busy_i = 1'b0; valu_ready_i = 1'b0; flu_valid_i = 1'b0; flu_trans_id_i = '0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_count",    64'(count_o), 64'd0);
        chk("rst_valid",    64'(valu_valid_o), 64'd0);
        chk("rst_mismatch", 64'(wb_mismatch_o), 64'd0);
        chk("rst_opa",      64'(operand_a_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Single op with same-cycle writeback
        valu_ready_i = 1'b1;
        drive_enq(3'd2, 32'd5, 32'd3);
        tick();
        in_valid_i = 1'b0; flu_valid_i = 1'b1; flu_trans_id_i = 3'd2;
        mid();
        chk("single_valid", 64'(valu_valid_o), 64'd1);
        chk("single_opa",   64'(operand_a_o), 64'd5);
        chk("single_opb",   64'(operand_b_o), 64'd3);
        chk("single_id",    64'(trans_id_o), 64'd2);
        chk("single_cnt",   64'(count_o), 64'd1);
        tick();
        flu_valid_i = 1'b0;
        mid();
        chk("single_after_valid", 64'(valu_valid_o), 64'd0);
        chk("single_after_cnt",   64'(count_o), 64'd0);
        chk("single_after_opa",   64'(operand_a_o), 64'd0);
        tick();

        // Back-pressure: fill, offer a fifth, then drain one per cycle
        valu_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_enq(3'(i), 32'h10 + 32'(i), 32'h20 + 32'(i));
            tick();
        end
        in_valid_i = 1'b0;
        mid();
        chk("bp_full_cnt",   64'(count_o), 64'd4);
        chk("bp_full_ready", 64'(in_ready_o), 64'd0);
        chk("bp_no_valid",   64'(valu_valid_o), 64'd0);
        tick();
        drive_enq(3'd7, 32'hff, 32'hff);
        tick();
        in_valid_i = 1'b0;
        mid();
        chk("bp_fifth_ignored", 64'(count_o), 64'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            valu_ready_i = 1'b1; flu_valid_i = 1'b1; flu_trans_id_i = 3'(i);
            mid();
            chk("bp_drain_valid", 64'(valu_valid_o), 64'd1);
            chk("bp_drain_id",    64'(trans_id_o), 64'(i));
            chk("bp_drain_opa",   64'(operand_a_o), 64'h10 + 64'(i));
            tick();
        end
        valu_ready_i = 1'b0; flu_valid_i = 1'b0;
        mid();
        chk("bp_empty_cnt",   64'(count_o), 64'd0);
        chk("bp_empty_valid", 64'(valu_valid_o), 64'd0);
        tick();

        // Port conflict: FLU busy for three cycles
        valu_ready_i = 1'b1; flu_busy_i = 1'b1;
        drive_enq(3'd4, 32'h44, 32'h55);
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("busy_valid", 64'(valu_valid_o), 64'd0);
            chk("busy_opa",   64'(operand_a_o), 64'd0);
            chk("busy_id",    64'(trans_id_o), 64'd0);
            tick();
        end
        flu_busy_i = 1'b0; flu_valid_i = 1'b1; flu_trans_id_i = 3'd4;
        mid();
        chk("busy_release_valid", 64'(valu_valid_o), 64'd1);
        chk("busy_release_opa",   64'(operand_a_o), 64'h44);
        tick();
        flu_valid_i = 1'b0;
        mid();
        chk("busy_done_cnt", 64'(count_o), 64'd0);
        tick();

        // Writeback timeout sets the sticky flag
        drive_enq(3'd5, 32'h55, 32'h66);
        tick();
        in_valid_i = 1'b0;
        mid();
        chk("wb_dispatch_id", 64'(trans_id_o), 64'd5);
        tick();
        flu_valid_i = 1'b1; flu_trans_id_i = 3'd1;
        mid();
        chk("wb_wait_no_dispatch", 64'(valu_valid_o), 64'd0);
        chk("wb_wait1_flag",       64'(wb_mismatch_o), 64'd0);
        tick();
        mid();
        chk("wb_wait2_flag", 64'(wb_mismatch_o), 64'd0);
        tick();
        flu_valid_i = 1'b0;
        mid();
        chk("wb_timeout_flag", 64'(wb_mismatch_o), 64'd1);
        tick();
        tick();
        mid();
        chk("wb_flag_sticky", 64'(wb_mismatch_o), 64'd1);
        tick();

        // Late but matching writeback while waiting
        drive_enq(3'd6, 32'h66, 32'h77);
        tick();
        in_valid_i = 1'b0;
        mid();
        chk("late_dispatch", 64'(valu_valid_o), 64'd1);
        tick();
        flu_valid_i = 1'b1; flu_trans_id_i = 3'd6;
        mid();
        chk("late_wait_valid", 64'(valu_valid_o), 64'd0);
        tick();
        flu_valid_i = 1'b0;
        mid();
        chk("late_flag_kept", 64'(wb_mismatch_o), 64'd1);
        chk("late_cnt",       64'(count_o), 64'd0);
        tick();

        // Flush with a concurrent enqueue
        valu_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_enq(3'(i), 32'(i), 32'(i));
            tick();
        end
        in_valid_i = 1'b0;
        mid();
        chk("flush_pre_cnt", 64'(count_o), 64'd3);
        tick();
        flush_i = 1'b1; valu_ready_i = 1'b1;
        drive_enq(3'd7, 32'h77, 32'h77);
        mid();
        chk("flush_cycle_valid", 64'(valu_valid_o), 64'd0);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        mid();
        chk("flush_cnt",      64'(count_o), 64'd0);
        chk("flush_valid",    64'(valu_valid_o), 64'd0);
        chk("flush_mismatch", 64'(wb_mismatch_o), 64'd0);
        chk("flush_ready",    64'(in_ready_o), 64'd1);
        tick();

        // Asynchronous reset mid-operation
        valu_ready_i = 1'b0;
        drive_enq(3'd1, 32'h1, 32'h1);
        tick();
        drive_enq(3'd2, 32'h2, 32'h2);
        tick();
        in_valid_i = 1'b0;
        mid();
        chk("arst_pre_cnt", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_cnt",   64'(count_o), 64'd0);
        chk("arst_ready", 64'(in_ready_o), 64'd1);
        tick();
        rst_ni = 1'b1;
        tick();

        // Wrap-around: overlapped enqueue/dispatch, ten ops through a 4-deep queue
        valu_ready_i = 1'b1;
        drive_enq(3'd0, 32'h100, 32'h200);
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) drive_enq(3'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
            else in_valid_i = 1'b0;
            flu_valid_i = 1'b1; flu_trans_id_i = 3'(i - 1);
            mid();
            chk("wrap_valid", 64'(valu_valid_o), 64'd1);
            chk("wrap_id",    64'(trans_id_o), 64'((i - 1) % 8));
            chk("wrap_opa",   64'(operand_a_o), 64'h100 + 64'(i - 1));
            chk("wrap_cnt",   64'(count_o), 64'd1);
            chk("wrap_ready", 64'(in_ready_o), 64'd1);
            tick();
        end
        flu_valid_i = 1'b0; valu_ready_i = 1'b0;
        mid();
        chk("wrap_end_cnt",      64'(count_o), 64'd0);
        chk("wrap_end_valid",    64'(valu_valid_o), 64'd0);
        chk("wrap_end_mismatch", 64'(wb_mismatch_o), 64'd0);
`ifdef VALU_ISSUE_STATS_EN
        chk("stats_dispatch", 64'(dispatch_cnt_o), 64'd10);
        chk("stats_stall",    64'(stall_cnt_o), 64'd0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/valu_issue_queue.md
Name: valu_issue_queue

Overview:
- Issue-side initiator for the VALU functional unit inside the execute stage; it drives the VALU valid/operand/trans-id inputs and observes the FLU writeback.
- Buffers up to DEPTH decoded VALU operations from issue and dispatches them one at a time onto the shared fixed-latency-unit (FLU) port.
- Dispatches only when the VALU is ready and the FLU port is free, then checks that each writeback returns the expected transaction ID.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_W, 32: operand width.
- TRANS_ID_BITS, 3: scoreboard transaction ID width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all queued and in-flight state.
- in_valid_i  in  1  issue offers a VALU op.
- in_ready_o  out  1  queue can accept; equals !full.
- in_operand_a_i  in  DATA_W  operand a.
- in_operand_b_i  in  DATA_W  operand b.
- in_trans_id_i  in  TRANS_ID_BITS  scoreboard ID of the op.
- flu_busy_i  in  1  another FLU source (ALU/branch/CSR/mult writeback) owns the port this cycle.
- valu_ready_i  in  1  VALU can accept an op.
- valu_valid_o  out  1  dispatch strobe toward the execute stage.
- operand_a_o  out  DATA_W  head operand a; 0 when valu_valid_o=0.
- operand_b_o  out  DATA_W  head operand b; 0 when valu_valid_o=0.
- trans_id_o  out  TRANS_ID_BITS  head trans ID; 0 when valu_valid_o=0.
- flu_valid_i  in  1  FLU writeback valid.
- flu_trans_id_i  in  TRANS_ID_BITS  FLU writeback ID.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- wb_mismatch_o  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0 except in_ready_o=1. Pointers 0, FSM IDLE.
- Queue is a circular buffer with wrapping read/write pointers, each carrying one extra wrap bit.
  - full when the pointers are equal and the wrap bits differ.
  - empty when the pointers and wrap bits are all equal.
- Enqueue on in_valid_i && in_ready_o.
- Dequeue happens on a dispatch cycle.
- Simultaneous enqueue and dequeue when full: enqueue is refused, since in_ready_o is registered-full based. Count is unchanged on a simultaneous enqueue and dequeue in any other state.
- FSM states:
  - IDLE: queue empty. Go to ARMED when count becomes nonzero (the cycle after enqueue).
  - ARMED: head present. grant = valu_ready_i && !flu_busy_i.
    - On grant: valu_valid_o=1 for exactly this one cycle, operands driven combinationally from the head entry, head popped, captured trans ID saved as expected_id. Next state is WAIT_WB.
    - No grant: stay in ARMED; outputs stay zero (data silence).
  - WAIT_WB: no dispatch.
    - On flu_valid_i && flu_trans_id_i==expected_id: go to ARMED if the queue is non-empty, else IDLE.
    - On flu_valid_i with any other ID: stay in WAIT_WB (another FU's writeback).
    - After 2 cycles without a match: set wb_mismatch_o and return to ARMED/IDLE.
- The VALU is single-cycle, so a dispatch-cycle writeback (flu_valid_i with a matching ID in the same cycle as valu_valid_o) counts as the match. In that case the FSM goes directly from ARMED to ARMED or IDLE, giving one op per cycle of throughput.
- wb_mismatch_o: cleared only by reset or flush.
- flush_i (highest priority, same-edge):
  - Pointers, count and expected_id are cleared.
  - FSM goes to IDLE.
  - Any enqueue in the flush cycle is dropped.
  - valu_valid_o is forced 0 in the flush cycle.
- Reset mid-operation: immediate asynchronous return to the reset values.

Optional Feature:
- Macro VALU_ISSUE_STATS_EN.
- When defined, adds two output ports:
  - dispatch_cnt_o (32 bits): +1 per dispatch.
  - stall_cnt_o (32 bits): +1 per ARMED cycle without grant.
  - Both are saturating, reset to 0, and are not cleared by flush.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Single op: enqueue a=0x0000_0005, b=0x0000_0003, id=2 with valu_ready_i=1, flu_busy_i=0, and a same-cycle writeback id=2 -> valu_valid_o pulses one cycle 1 cycle after enqueue, with operand_a_o=5, operand_b_o=3, trans_id_o=2; FSM returns to IDLE; count_o=0.
- Back-pressure: enqueue 4 ops with valu_ready_i=0 -> in_ready_o=0, count_o=4, a fifth in_valid_i is ignored. Raise valu_ready_i -> 4 consecutive one-cycle dispatches in FIFO order with IDs 0,1,2,3.
- Port conflict: head present, flu_busy_i=1 for 3 cycles -> no dispatch and outputs all 0; dispatch occurs on the first cycle flu_busy_i=0.
- Writeback check: dispatch id=5, then return only flu_trans_id_i=1 for 2 cycles -> wb_mismatch_o=1 and it stays set until flush.
- Flush: 3 ops queued, assert flush_i together with in_valid_i -> next cycle count_o=0, valu_valid_o=0, wb_mismatch_o=0, in_ready_o=1.
- Wrap-around: 10 enqueue/dispatch pairs with DEPTH=4 -> IDs emerge in order, no spurious full/empty. With VALU_ISSUE_STATS_EN, dispatch_cnt_o=10.
